uart_tx_block: RTL and testbench
================================

# uart_tx_block

Serial transmitter that turns a parallel byte into an asynchronous serial frame: one start bit, LSB-first data, optional even parity, one stop bit. Pairs with the team's flex-counter-based serial receiver as the transmitting end of the same link and uses the same bit period (`CLKS_PER_BIT` clocks per bit). The bit timer follows flex-counter semantics: it counts 1..`CLKS_PER_BIT` and then rolls over to 1.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; range 5..8.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after the data bits.

Ports:
- `clk`, in, 1: single system clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `tx_data`, in, `DATA_BITS`: byte to send; sampled only on an accepted start.
- `tx_start`, in, 1: start request; accepted only when `tx_busy` = 0.
- `serial_out`, out, 1: serial line; idles high (1).
- `tx_busy`, out, 1: 1 from the accepting edge until the stop bit completes.
- `tx_done`, out, 1: one-cycle pulse when the stop bit completes.
- `start_err`, out, 1: one-cycle pulse when `tx_start` = 1 while `tx_busy` = 1.

## Operation

- Every output is registered.
- Reset values (`rst` = 1 at an edge): `serial_out` = 1, `tx_busy` = 0, `tx_done` = 0, `start_err` = 0, state = IDLE, bit timer = 0, bit index = 0.
- State machine: IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- **IDLE:** `serial_out` = 1. If `tx_start` = 1 at an edge:
  - latch `tx_data` into the shift register;
  - compute parity as the XOR of the data bits;
  - go to START and set `tx_busy` = 1.
- **START:** `serial_out` = 0 for `CLKS_PER_BIT` cycles.
- **DATA:** `serial_out` = shift_reg[0]. On each timer rollover:
  - shift right and increment the bit index;
  - after bit index `DATA_BITS`-1, go to PARITY or STOP.
- **PARITY:** `serial_out` = the latched parity bit, making the count of 1s across data+parity even. Lasts `CLKS_PER_BIT` cycles.
- **STOP:** `serial_out` = 1 for `CLKS_PER_BIT` cycles. On rollover:
  - go to IDLE;
  - `tx_busy` = 0 and `tx_done` = 1 for exactly one cycle.
- **Bit timer:**
  - loads 1 on entry to START;
  - increments every cycle while `tx_busy` = 1;
  - on reaching `CLKS_PER_BIT` it rolls over to 1 on the next edge, and a state/bit advance happens on that same edge.
  - Timer width is `$clog2(CLKS_PER_BIT+1)`.
- **Ignored starts:** `tx_start` while busy is ignored. Data and timing are unaffected, and `start_err` pulses on the next cycle.
- **Data stability:** `tx_data` may change freely after acceptance; the transmitted frame uses only the latched copy.
- **Reset mid-frame:** on the next edge the block returns to the reset values above. The line goes high immediately (a truncated frame is acceptable). No `tx_done` pulse.
- **Held start:** `tx_start` held high continuously sends back-to-back frames, one accepted per IDLE cycle.

## Timing

- Frame length F = (1 + `DATA_BITS` + `PARITY_EN` + 1) × `CLKS_PER_BIT` cycles. With defaults, F = 100.
- Accept at edge k:
  - `serial_out` = 0 and `tx_busy` = 1 from edge k;
  - data bit i is driven from edge k + (1+i)·`CLKS_PER_BIT`;
  - the stop bit is driven from edge k + (1 + `DATA_BITS` + `PARITY_EN`)·`CLKS_PER_BIT`.
- End of frame: at edge k+F, `tx_busy` = 0 and `tx_done` = 1. `tx_done` clears at edge k+F+1.
- Back-to-back: the next start is accepted at the earliest at edge k+F+1, because the IDLE dwell is one cycle. The minimum frame-to-frame period is F+1 cycles, and the line stays high during the extra cycle.
- `tx_start` that is high in the same cycle `tx_done` is high is accepted at the next edge.
- All inputs must be stable around the rising edge. The bench applies inputs on the falling edge and checks just before the next rising edge.

## Test plan

- **Reset:** assert `rst` for 2 cycles, also mid-frame at cycle 35 → `serial_out` = 1, `tx_busy` = 0, `tx_done` = 0 after the next edge; no further line activity.
- **Single frame:** defaults, `tx_data` = 0xA5, pulse `tx_start` for 1 cycle → line holds 0 (start), then 1,0,1,0,0,1,0,1 each for 10 cycles, then 1 (stop) for 10 cycles. `tx_done` pulses at cycle 100 and `tx_busy` is high for exactly cycles 0–99.
- **Parity:** `PARITY_EN` = 1:
  - `tx_data` = 0xA5 → parity bit 0 at cycles 90–99;
  - `tx_data` = 0x07 → parity bit 1;
  - `tx_done` at cycle 110.
- **Start while busy:** pulse `tx_start` with `tx_data` = 0x3C at cycle 40 of a 0xA5 frame → frame still 0xA5, `start_err` is a 1-cycle pulse, no second frame.
- **Held start / back-to-back:** hold `tx_start` = 1 with `tx_data` = 0x00 then 0xFF:
  - second start bit begins exactly 101 cycles after the first;
  - `tx_done` pulses once per frame;
  - line is high for the one IDLE cycle.
- **Short period:** `CLKS_PER_BIT` = 2, `DATA_BITS` = 5, `tx_data` = 0x15 → frame length 14 cycles, bits 1,0,1,0,1, timer rollover every 2 cycles.

Source files
------------

// File: rtl/uart_tx_block.sv
// Serial byte transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Bit period is CLKS_PER_BIT clocks, timed by a 1..CLKS_PER_BIT rolling counter.
module uart_tx_block #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 start_err
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT);
  localparam logic [IW-1:0] ILAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic [IW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_serial, r_busy, r_done, r_start_err;
  logic                 w_serial_nxt, w_busy_nxt, w_done_nxt, w_start_err_nxt;
  logic                 w_roll;

  assign w_roll = (r_timer == TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_serial    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_parity    <= w_parity_nxt;
      r_serial    <= w_serial_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_start_err <= w_start_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    if (r_state != S_IDLE) begin
      w_timer_nxt = w_roll ? TW'(1) : r_timer + 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = tx_data;
          w_parity_nxt  = ^tx_data;
          w_timer_nxt   = TW'(1);
          w_bit_idx_nxt = '0;
        end
      end
      S_START: begin
        if (w_roll) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_roll) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == ILAST) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_roll) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_roll) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state to line up with it.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = w_parity_nxt;
      default:  w_serial_nxt = 1'b1;
    endcase
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (r_state == S_STOP) && w_roll;
    w_start_err_nxt = tx_start && r_busy;
  end

  assign serial_out = r_serial;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign start_err  = r_start_err;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: three configurations (default, parity, short period)
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_block;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start;
  logic [7:0] a_data;
  logic       a_ser, a_busy, a_done, a_err;

  logic       b_start;
  logic [7:0] b_data;
  logic       b_ser, b_busy, b_done, b_err;

  logic       c_start;
  logic [4:0] c_data;
  logic       c_ser, c_busy, c_done, c_err;

  int total = 0;
  int bad   = 0;

  uart_tx_block #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_start(a_start),
    .serial_out(a_ser), .tx_busy(a_busy), .tx_done(a_done), .start_err(a_err)
  );

  uart_tx_block #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_start(b_start),
    .serial_out(b_ser), .tx_busy(b_busy), .tx_done(b_done), .start_err(b_err)
  );

  uart_tx_block #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0)) u_c (
    .clk(clk), .rst(rst), .tx_data(c_data), .tx_start(c_start),
    .serial_out(c_ser), .tx_busy(c_busy), .tx_done(c_done), .start_err(c_err)
  );

  // Expected line level t cycles after the accepting edge, from the frame layout.
  function automatic logic model_line(input int data, input int nbits, input int par,
                                      input int cpb, input int t);
    int f;
    int slot;
    int v;
    f = (nbits + par + 2) * cpb;
    if (t < 0 || t >= f) return 1'b1;
    slot = t / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= nbits) begin
      v = data >> (slot - 1);
      return v[0];
    end
    if (par != 0 && slot == nbits + 1) begin
      v = $countones(data & ((1 << nbits) - 1));
      return v[0];
    end
    return 1'b1;
  endfunction

  task automatic test_reset();
    int f;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (a_ser !== 1'b1)  begin bad++; $display("FAIL reset_ser got=%b exp=1", a_ser); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_done); end
    total++; if (a_err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%b exp=0", a_err); end
    total++; if (b_ser !== 1'b1 || c_ser !== 1'b1) begin
      bad++; $display("FAIL reset_ser_bc got=%b%b exp=11", b_ser, c_ser);
    end
    rst = 1'b0;
    // mid-frame reset at cycle 35
    f = 100;
    a_data = 8'hA5; a_start = 1'b1;
    for (int t = 0; t <= 35; t++) begin
      @(negedge clk);
      total++;
      if (a_ser !== model_line(32'hA5, 8, 0, 10, t)) begin
        bad++; $display("FAIL midrst_line t=%0d got=%b exp=%b", t, a_ser, model_line(32'hA5, 8, 0, 10, t));
      end
      if (t == 0) a_start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (a_ser !== 1'b1)  begin bad++; $display("FAIL midrst_ser got=%b exp=1", a_ser); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", a_done); end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < f + 20; t++) begin
      @(negedge clk);
      total++;
      if (a_ser !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
        bad++; $display("FAIL postrst_quiet t=%0d ser=%b busy=%b done=%b exp=1/0/0", t, a_ser, a_busy, a_done);
      end
    end
  endtask

  task automatic test_single_frame();
    int f;
    f = 100;
    @(negedge clk);
    a_data = 8'hA5; a_start = 1'b1;
    for (int t = 0; t <= f + 2; t++) begin
      @(negedge clk);
      total++;
      if (a_ser !== model_line(32'hA5, 8, 0, 10, t)) begin
        bad++; $display("FAIL single_line t=%0d got=%b exp=%b", t, a_ser, model_line(32'hA5, 8, 0, 10, t));
      end
      total++;
      if (a_busy !== (t < f)) begin
        bad++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, a_busy, (t < f));
      end
      total++;
      if (a_done !== (t == f)) begin
        bad++; $display("FAIL single_done t=%0d got=%b exp=%b", t, a_done, (t == f));
      end
      if (t == 0) begin
        a_start = 1'b0;
        a_data  = 8'($urandom);
      end
    end
  endtask

  task automatic test_parity();
    int f;
    int d;
    f = 110;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 32'hA5 : 32'h07;
      @(negedge clk);
      b_data = 8'(d); b_start = 1'b1;
      for (int t = 0; t <= f + 1; t++) begin
        @(negedge clk);
        total++;
        if (b_ser !== model_line(d, 8, 1, 10, t)) begin
          bad++; $display("FAIL parity_line d=%0h t=%0d got=%b exp=%b", d, t, b_ser, model_line(d, 8, 1, 10, t));
        end
        total++;
        if (b_done !== (t == f) || b_busy !== (t < f)) begin
          bad++; $display("FAIL parity_ctl d=%0h t=%0d done=%b busy=%b exp=%b/%b", d, t, b_done, b_busy, (t == f), (t < f));
        end
        if (t == 0) begin
          b_start = 1'b0;
          b_data  = 8'($urandom);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int f;
    f = 100;
    @(negedge clk);
    a_data = 8'hA5; a_start = 1'b1;
    for (int t = 0; t <= f + 30; t++) begin
      @(negedge clk);
      total++;
      if (a_ser !== model_line(32'hA5, 8, 0, 10, t)) begin
        bad++; $display("FAIL busystart_line t=%0d got=%b exp=%b", t, a_ser, model_line(32'hA5, 8, 0, 10, t));
      end
      total++;
      if (a_err !== (t == 41)) begin
        bad++; $display("FAIL busystart_err t=%0d got=%b exp=%b", t, a_err, (t == 41));
      end
      total++;
      if (a_busy !== (t < f) || a_done !== (t == f)) begin
        bad++; $display("FAIL busystart_ctl t=%0d busy=%b done=%b exp=%b/%b", t, a_busy, a_done, (t < f), (t == f));
      end
      if (t == 0)  a_start = 1'b0;
      if (t == 40) begin a_start = 1'b1; a_data = 8'h3C; end
      if (t == 41) a_start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int f;
    logic exp_l, exp_b, exp_d;
    f = 100;
    @(negedge clk);
    a_data = 8'h00; a_start = 1'b1;
    for (int t = 0; t <= 2 * f + 4; t++) begin
      @(negedge clk);
      if (t <= f) exp_l = model_line(32'h00, 8, 0, 10, t);
      else        exp_l = model_line(32'hFF, 8, 0, 10, t - f - 1);
      exp_b = (t < f) || (t >= f + 1 && t < 2 * f + 1);
      exp_d = (t == f) || (t == 2 * f + 1);
      total++;
      if (a_ser !== exp_l) begin
        bad++; $display("FAIL b2b_line t=%0d got=%b exp=%b", t, a_ser, exp_l);
      end
      total++;
      if (a_busy !== exp_b || a_done !== exp_d) begin
        bad++; $display("FAIL b2b_ctl t=%0d busy=%b done=%b exp=%b/%b", t, a_busy, a_done, exp_b, exp_d);
      end
      if (t == 0)     a_data  = 8'hFF;
      if (t == f + 1) a_start = 1'b0;
    end
  endtask

  task automatic test_short_period();
    int f;
    int d;
    f = 14;
    for (int k = 0; k < 4; k++) begin
      d = (k == 0) ? 32'h15 : int'($urandom_range(0, 31));
      @(negedge clk);
      c_data = 5'(d); c_start = 1'b1;
      for (int t = 0; t <= f + 1; t++) begin
        @(negedge clk);
        total++;
        if (c_ser !== model_line(d, 5, 0, 2, t)) begin
          bad++; $display("FAIL short_line d=%0h t=%0d got=%b exp=%b", d, t, c_ser, model_line(d, 5, 0, 2, t));
        end
        total++;
        if (c_busy !== (t < f) || c_done !== (t == f)) begin
          bad++; $display("FAIL short_ctl d=%0h t=%0d busy=%b done=%b exp=%b/%b", d, t, c_busy, c_done, (t < f), (t == f));
        end
        if (t == 0) begin
          c_start = 1'b0;
          c_data  = 5'($urandom);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    int d;
    int gap;
    for (int k = 0; k < 6; k++) begin
      d   = int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 5));
      repeat (gap) @(negedge clk);
      @(negedge clk);
      a_data = 8'(d); a_start = 1'b1;
      b_data = 8'(d); b_start = 1'b1;
      for (int t = 0; t <= 111; t++) begin
        @(negedge clk);
        total++;
        if (a_ser !== model_line(d, 8, 0, 10, t) || a_done !== (t == 100)) begin
          bad++; $display("FAIL rand_a d=%0h t=%0d ser=%b done=%b", d, t, a_ser, a_done);
        end
        total++;
        if (b_ser !== model_line(d, 8, 1, 10, t) || b_done !== (t == 110)) begin
          bad++; $display("FAIL rand_b d=%0h t=%0d ser=%b done=%b", d, t, b_ser, b_done);
        end
        if (t == 0) begin
          a_start = 1'b0; b_start = 1'b0;
          a_data = 8'($urandom); b_data = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_data = '0;
    b_start = 1'b0; b_data = '0;
    c_start = 1'b0; c_data = '0;
    test_reset();
    test_single_frame();
    test_parity();
    test_start_while_busy();
    test_back_to_back();
    test_short_period();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
